// File: rtl/sdio_crc_lanes.sv
// rtl/sdio_crc_lanes.sv - Multi-lane SDIO data CRC engine: accumulate, then shift out (TX) or check (RX).
// Optional per-block RX error counter output err_cnt enabled by SDIO_CRC_ERR_CNT_EN.
module sdio_crc_lanes #(
    parameter int                 LANES = 4,
    parameter int                 CRC_W = 16,
    parameter logic [CRC_W-1:0]   POLY  = 16'h1021,
    parameter logic [CRC_W-1:0]   INIT  = 16'h0000,
    parameter int                 LEN_W = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   mode,
    input  logic [LEN_W-1:0]       blk_len,
    input  logic                   bit_en,
    input  logic [LANES-1:0]       din,
    output logic [LANES-1:0]       dout,
    output logic                   dout_crc,
    output logic                   busy,
    output logic                   done,
    output logic                   crc_ok,
    output logic [LANES-1:0]       crc_err,
`ifdef SDIO_CRC_ERR_CNT_EN
    output logic [7:0]             err_cnt,
`endif
    output logic [LANES*CRC_W-1:0] crc_reg
);

    localparam int CNT_W = (LEN_W > $clog2(CRC_W + 1)) ? LEN_W : $clog2(CRC_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC, S_END} state_t;

    state_t           state, state_nxt;
    logic [CRC_W-1:0] crc [LANES];
    logic [CNT_W-1:0] cnt;
    logic             mode_q;
    logic [LANES-1:0] err_q;
    logic [LANES-1:0] mism;
    logic             ok_q;
    logic             last_bit;

    assign last_bit = (cnt == CNT_W'(1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = (blk_len == '0) ? S_CRC : S_DATA;
            S_DATA: if (bit_en && last_bit) state_nxt = S_CRC;
            S_CRC:  if (bit_en && last_bit) state_nxt = S_END;
            S_END:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Received CRC bit compared against the register MSB before it shifts.
    always_comb begin
        mism = '0;
        for (int l = 0; l < LANES; l++) begin
            mism[l] = mode_q && (state == S_CRC) && bit_en && (din[l] != crc[l][CRC_W-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mode_q <= 1'b0;
            err_q  <= '0;
            ok_q   <= 1'b0;
            for (int l = 0; l < LANES; l++) crc[l] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        err_q  <= '0;
                        ok_q   <= 1'b0;
                        cnt    <= (blk_len == '0) ? CNT_W'(CRC_W) : CNT_W'(blk_len);
                        for (int l = 0; l < LANES; l++) crc[l] <= INIT;
                    end
                end
                S_DATA: begin
                    if (bit_en) begin
                        for (int l = 0; l < LANES; l++) begin
                            crc[l] <= {crc[l][CRC_W-2:0], 1'b0}
                                    ^ ((din[l] ^ crc[l][CRC_W-1]) ? POLY : '0);
                        end
                        cnt <= last_bit ? CNT_W'(CRC_W) : cnt - 1'b1;
                    end
                end
                S_CRC: begin
                    if (bit_en) begin
                        for (int l = 0; l < LANES; l++) crc[l] <= {crc[l][CRC_W-2:0], 1'b0};
                        err_q <= err_q | mism;
                        cnt   <= cnt - 1'b1;
                        if (last_bit) ok_q <= mode_q & ~|(err_q | mism);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SDIO_CRC_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= 8'h00;
        end else if ((state == S_END) && mode_q && (|err_q) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end
`endif

    always_comb begin
        dout    = '0;
        crc_reg = '0;
        for (int l = 0; l < LANES; l++) begin
            dout[l]                    = crc[l][CRC_W-1];
            crc_reg[l*CRC_W +: CRC_W]  = crc[l];
        end
    end

    assign dout_crc = (state == S_CRC) && !mode_q;
    assign busy     = (state == S_DATA) || (state == S_CRC);
    assign done     = (state == S_END);
    assign crc_ok   = ok_q;
    assign crc_err  = err_q;

endmodule

// File: tb/tb_sdio_crc_lanes.sv
// tb/tb_sdio_crc_lanes.sv - Self-checking bench for sdio_crc_lanes (4 lanes, 13-bit length).
module tb_sdio_crc_lanes;
    localparam int LANES = 4;
    localparam int CRC_W = 16;
    localparam int LEN_W = 13;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             mode = 1'b0;
    logic [LEN_W-1:0] blk_len = '0;
    logic             bit_en = 1'b0;
    logic [LANES-1:0] din = '0;
    logic [LANES-1:0] dout;
    logic             dout_crc;
    logic             busy;
    logic             done;
    logic             crc_ok;
    logic [LANES-1:0] crc_err;
    logic [LANES*CRC_W-1:0] crc_reg;
`ifdef SDIO_CRC_ERR_CNT_EN
    logic [7:0]       err_cnt;
    int               cnt_exp = 0;
`endif

    sdio_crc_lanes #(.LANES(LANES), .CRC_W(CRC_W), .POLY(16'h1021), .INIT(16'h0000), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .blk_len(blk_len), .bit_en(bit_en),
        .din(din), .dout(dout), .dout_crc(dout_crc), .busy(busy), .done(done), .crc_ok(crc_ok),
        .crc_err(crc_err),
`ifdef SDIO_CRC_ERR_CNT_EN
        .err_cnt(err_cnt),
`endif
        .crc_reg(crc_reg)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    bit          dbits [LANES][4096];
    logic [15:0] exp_crc [LANES];

    typedef struct {
        bit          m;
        int          len;
        int          pat;
        logic [3:0]  flip;
        logic [15:0] exp;
        int          gapmax;
        bit          inject;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // CRC as remainder of M(x)*x^16 divided by G(x), by long division.
    function automatic logic [15:0] ref_crc(input int lane, input int n);
        bit          a[$];
        bit [16:0]   g;
        logic [15:0] r;
        g = 17'h11021;
        for (int i = 0; i < n; i++) a.push_back(dbits[lane][i]);
        repeat (16) a.push_back(1'b0);
        for (int i = 0; i < n; i++)
            if (a[i]) for (int j = 0; j < 17; j++) a[i+j] = a[i+j] ^ g[16-j];
        r = '0;
        for (int j = 0; j < 16; j++) r = {r[14:0], a[n+j]};
        return r;
    endfunction

    task automatic fill(input int l, input int pat, input int len);
        logic [7:0] c;
        for (int i = 0; i < len; i++) begin
            case (pat)
                0: dbits[l][i] = 1'b1;
                1: begin c = 8'h31 + 8'(i / 8); dbits[l][i] = c[7 - (i % 8)]; end
                default: dbits[l][i] = 1'($urandom);
            endcase
        end
    endtask

    task automatic gap(input int gapmax, input bit inject);
        int g;
        g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
        repeat (g) begin
            bit_en = 1'b0;
            din    = 4'($urandom);
            if (inject && $urandom_range(0, 2) == 0) begin
                start = 1'b1; mode = 1'($urandom); blk_len = 13'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic run_block(input bit m, input int len, input int gapmax, input bit inject,
                             input logic [3:0] flip);
        logic [15:0] tx [LANES];
        mode = m; blk_len = LEN_W'(len); start = 1'b1; bit_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < len; i++) begin
            gap(gapmax, inject);
            bit_en = 1'b1;
            for (int l = 0; l < LANES; l++) din[l] = dbits[l][i];
            @(negedge clk);
        end
        bit_en = 1'b0;
        for (int l = 0; l < LANES; l++) chk("crc_after_data", crc_reg[l*16 +: 16], exp_crc[l]);
        for (int k = 0; k < 16; k++) begin
            gap(gapmax, inject);
            chk("dout_crc_phase", dout_crc, !m);
            for (int l = 0; l < LANES; l++) begin
                tx[l][15-k] = dout[l];
                din[l] = exp_crc[l][15-k] ^ (flip[l] && k == 5);
            end
            bit_en = 1'b1;
            @(negedge clk);
        end
        bit_en = 1'b0; din = '0;
        chk("done_pulse", done, 1);
        chk("busy_in_end", busy, 0);
        chk("dout_crc_end", dout_crc, 0);
        chk("crc_ok_end", crc_ok, (m && flip == 4'b0000));
        chk("crc_err_end", crc_err, m ? flip : 4'b0000);
        if (!m) for (int l = 0; l < LANES; l++) chk("tx_stream", tx[l], exp_crc[l]);
`ifdef SDIO_CRC_ERR_CNT_EN
        if (m && flip != 4'b0000 && cnt_exp < 255) cnt_exp++;
`endif
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("crc_ok_held", crc_ok, (m && flip == 4'b0000));
`ifdef SDIO_CRC_ERR_CNT_EN
        chk("err_cnt", err_cnt, cnt_exp);
`endif
    endtask

    initial begin
        int dn;
        vecs[0] = '{0, 1,    0, 4'b0000, 16'h1021, 0, 0};
        vecs[1] = '{0, 0,    0, 4'b0000, 16'h0000, 0, 0};
        vecs[2] = '{1, 72,   1, 4'b0000, 16'h31C3, 0, 0};
        vecs[3] = '{1, 72,   1, 4'b0100, 16'h31C3, 0, 0};
        vecs[4] = '{0, 4096, 0, 4'b0000, 16'h7FA1, 0, 0};
        vecs[5] = '{1, 72,   1, 4'b0000, 16'h31C3, 5, 1};
        vecs[6] = '{0, 1,    0, 4'b0000, 16'h1021, 4, 1};

        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_crc_reg", crc_reg, 0);
        chk("reset_dout", dout, 0);
        chk("reset_dout_crc", dout_crc, 0);
        chk("reset_crc_ok", crc_ok, 0);
        chk("reset_crc_err", crc_err, 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[v]) begin
            for (int l = 0; l < LANES; l++) begin
                fill(l, vecs[v].pat, vecs[v].len);
                exp_crc[l] = vecs[v].exp;
            end
            run_block(vecs[v].m, vecs[v].len, vecs[v].gapmax, vecs[v].inject, vecs[v].flip);
        end

        for (int r = 0; r < 20; r++) begin
            int  len;
            bit  m;
            len = $urandom_range(0, 200);
            m   = 1'($urandom);
            for (int l = 0; l < LANES; l++) begin
                fill(l, 2, len);
                exp_crc[l] = ref_crc(l, len);
            end
            run_block(m, len, $urandom_range(0, 3), 1'($urandom),
                      (m && $urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000);
        end

`ifdef SDIO_CRC_ERR_CNT_EN
        for (int l = 0; l < LANES; l++) exp_crc[l] = 16'h0000;
        for (int r = 0; r < 300; r++) run_block(1'b1, 0, 0, 1'b0, 4'b0001);
        chk("err_cnt_saturated", err_cnt, 8'hFF);
        run_block(1'b1, 0, 0, 1'b0, 4'b0000);
`endif

        for (int l = 0; l < LANES; l++) fill(l, 2, 50);
        mode = 1'b0; blk_len = 13'd50; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bit_en = 1'(i % 2); din = 4'($urandom);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_crc_reg", crc_reg, 0);
        chk("rst_crc_err", crc_err, 0);
        chk("rst_done", done, 0);
        chk("rst_dout", dout, 0);
`ifdef SDIO_CRC_ERR_CNT_EN
        chk("rst_err_cnt", err_cnt, 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            bit_en = 1'($urandom); din = 4'($urandom);
            @(negedge clk);
            if (done) dn++;
        end
        chk("no_done_after_abort", dn, 0);
        chk("idle_after_abort", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdio_crc_lanes.md
Name: sdio_crc_lanes

Overview:
Parametrised multi-lane serial CRC engine for the SDIO client data path: one CRC register per DAT lane (1/4/8-bit bus modes).
- Sequenced by an internal block FSM. In TX mode it accumulates the data bits, then shifts the CRC out.
- In RX mode it accumulates the data bits, then compares the received CRC bits per lane.
- Sits between the data shift logic and the DAT pad drivers/receivers, and replaces per-lane hand-sequenced CRC16 instances.

Parameters:
LANES, 4, number of independent data lanes (1..8)
CRC_W, 16, CRC register width
POLY, 16'h1021, generator polynomial without the implicit x^CRC_W term
INIT, 16'h0000, CRC register value loaded on start
LEN_W, 12, width of blk_len

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  single-cycle pulse; begins a block; ignored while busy=1
mode  in  1  0=TX (generate and shift out), 1=RX (check); sampled with start
blk_len  in  LEN_W  data bits per lane in this block; sampled with start
bit_en  in  1  one bit-time strobe; all shifting and counting happens only when bit_en=1
din  in  LANES  serial data in, one bit per lane
dout  out  LANES  per-lane CRC MSB (crc[l][CRC_W-1])
dout_crc  out  1  high while FSM is in CRC phase and mode=TX (pad mux select)
busy  out  1  high in DATA or CRC state
done  out  1  one-cycle pulse at end of block
crc_ok  out  1  RX result: all lanes matched; held until next start
crc_err  out  LANES  per-lane sticky mismatch flags; held until next start
crc_reg  out  LANES*CRC_W  concatenated CRC registers, lane 0 in the LSBs

Behaviour:
- Reset rst, asynchronous, active-high; clock clk. Reset: state IDLE, all crc lanes 0, counters 0, dout=0, dout_crc=0, busy=0, done=0, crc_ok=0, crc_err=0.
- FSM states: IDLE, DATA, CRC, END.
- IDLE: when start=1:
  - load every lane with INIT; latch mode and blk_len; clear crc_err and crc_ok; load bit counter with blk_len.
  - next state is DATA, or CRC if blk_len=0.
- DATA, on each bit_en:
  - per lane: fb = din[l] ^ crc[l][CRC_W-1]; crc[l] <= {crc[l][CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
  - decrement counter. When the strobe consumes the last bit (counter==1): load counter with CRC_W and go to CRC.
- CRC, on each bit_en:
  - per lane: crc[l] <= {crc[l][CRC_W-2:0],1'b0}.
  - RX only: if din[l] != crc[l][CRC_W-1] before the shift, set crc_err[l].
  - decrement counter; on the last CRC bit go to END.
- END: for exactly one cycle, done=1 and crc_ok = mode & ~|crc_err (0 in TX mode). Then IDLE.
- TX ordering: dout presents the CRC MSB first, combinationally from the register. The first CRC bit is valid in the cycle after the last data bit_en.
- Latency: total bit_en strobes per block = blk_len + CRC_W. done asserts one clk after the final strobe.
- bit_en=0 freezes all state (except END, which always lasts exactly one cycle).
- start during DATA/CRC/END: ignored, no effect.
- Changes to mode or blk_len while busy: no effect.
- rst mid-block: immediate abort to the reset state; no done pulse.
- crc_reg is readable at all times.

Optional Feature:
SDIO_CRC_ERR_CNT_EN
- Defined: adds output err_cnt[7:0], reset 0. Increments by 1 in the END cycle of every RX block with any crc_err bit set, saturating at 8'hFF. Cleared only by rst.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset check: assert rst mid-DATA with bit_en toggling -> immediately busy=0, crc_reg=0, done never pulses, crc_err=0.
- LANES=1, TX, blk_len=1, din=1 -> crc_reg=16'h1021 after data; next 16 dout bits MSB-first 0001000000100001; done one cycle after 17th strobe; crc_ok=0.
- LANES=4, TX, blk_len=4096, all lanes din=1 (512 bytes of 0xFF) -> each lane crc=16'h7FA1; dout_crc high for exactly 16 strobes.
- LANES=4, RX, blk_len=72, lanes carry ASCII "123456789" MSB-first followed by 16'h31C3 -> crc_err=4'b0000, crc_ok=1 at done. Flip one CRC bit on lane 2 -> crc_err=4'b0100, crc_ok=0.
- Edge cases:
  - blk_len=0 -> goes straight to CRC; TX shifts out INIT (16'h0000); done after 16 strobes.
  - start pulsed while busy -> ignored.
  - bit_en gaps of random length -> results identical to back-to-back strobes.
- With SDIO_CRC_ERR_CNT_EN: 300 RX blocks each with a lane-0 error -> err_cnt saturates at 8'hFF. Good blocks do not increment it.
